// File: rtl/muldiv_iter.sv
// muldiv_iter: shared iterative multiply/divide engine for the EX stage.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start_i, op_i        request (sampled in IDLE only); 00 multu, 01 mult, 10 divu, 11 div
//   opdata1_i/opdata2_i  multiplicand/dividend, multiplier/divisor
//   annul_i              abort the requested or in-flight operation
//   busy_o, ready_o      engine not idle; one-cycle result-valid pulse
//   result_o             {hi, lo} = product, or {remainder, quotient}
//   div_by_zero_o        divisor was zero; valid with ready_o, held afterwards
module muldiv_iter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_by_zero_o
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned N_MUL = WIDTH / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W2-1:0]      r_acc;     // product accumulator; hi half is the partial remainder for divide
  logic [W2-1:0]      r_a;       // shifting multiplicand, or divisor in the low half
  logic [WIDTH-1:0]   r_b;       // multiplier bits still to retire, or dividend/quotient shifter
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_a;
  logic               r_neg_b;

  logic               w_accept;
  logic               w_dbz_in;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic               w_last;
  logic [W2-1:0]      w_pp;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_sub;
  logic               w_qbit;
  logic [W2-1:0]      w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [W2-1:0]      w_fixed;

  assign w_accept = start_i & ~annul_i;
  assign w_dbz_in = op_i[1] & (opdata2_i == '0);
  // magnitudes only for signed ops (op_i[0])
  assign w_abs1   = (op_i[0] & opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign w_abs2   = (op_i[0] & opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
  assign w_last   = (r_cnt == (r_is_div ? CNT_W'(WIDTH - 1) : CNT_W'(N_MUL - 1)));

  // multiply step: partial product of the next MUL_BITS multiplier bits
  assign w_pp     = r_a * W2'(r_b[MUL_BITS-1:0]);

  // restoring divide step: bring in next dividend bit, subtract if it fits
  assign w_rem    = r_acc[W2-1:WIDTH];
  assign w_shift  = {w_rem, r_b[WIDTH-1]};
  assign w_qbit   = (w_shift >= {1'b0, r_a[WIDTH-1:0]});
  assign w_sub    = w_shift - {1'b0, r_a[WIDTH-1:0]};

  // sign fix-up of magnitude results
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~r_acc + W2'(1)) : r_acc;
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? (~r_b + WIDTH'(1)) : r_b;
  assign w_rem_fix  = r_neg_a ? (~w_rem + WIDTH'(1)) : w_rem;
  assign w_fixed    = r_is_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_dbz_in ? S_DONE : S_CALC;
      S_CALC: begin
        if (annul_i)     w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = annul_i ? S_IDLE : S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_acc         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_cnt         <= '0;
      r_is_div      <= 1'b0;
      r_neg_a       <= 1'b0;
      r_neg_b       <= 1'b0;
      busy_o        <= 1'b0;
      ready_o       <= 1'b0;
      result_o      <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      busy_o  <= (w_state_nxt != S_IDLE);
      ready_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= op_i[1];
            r_neg_a  <= op_i[0] & opdata1_i[WIDTH-1];
            r_neg_b  <= op_i[0] & opdata2_i[WIDTH-1];
            r_cnt    <= '0;
            r_acc    <= '0;
            if (op_i[1]) begin
              r_a <= W2'(w_abs2);
              r_b <= w_abs1;
            end else begin
              r_a <= W2'(w_abs1);
              r_b <= w_abs2;
            end
            // zero divisor short-circuits straight to DONE with the raw dividend in hi
            if (w_dbz_in) begin
              result_o      <= {opdata1_i, {WIDTH{1'b1}}};
              div_by_zero_o <= 1'b1;
              ready_o       <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_acc[W2-1:WIDTH] <= WIDTH'(w_qbit ? w_sub : w_shift);
            r_b               <= WIDTH'({r_b, w_qbit});
          end else begin
            r_acc <= r_acc + w_pp;
            r_a   <= r_a << MUL_BITS;
            r_b   <= r_b >> MUL_BITS;
          end
        end
        S_FIX: begin
          if (!annul_i) begin
            result_o      <= w_fixed;
            div_by_zero_o <= 1'b0;
            ready_o       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: one WIDTH=32 instance with MUL_BITS=1 and one with MUL_BITS=4,
// checked against an arithmetic reference model.
module tb_muldiv_iter;

  logic        clk;
  logic        resetn;
  logic        start1, start4;
  logic [1:0]  op;
  logic [31:0] d1, d2;
  logic        annul;
  logic        busy1, ready1, dbz1;
  logic        busy4, ready4, dbz4;
  logic [63:0] res1, res4;

  int errors = 0;
  int checks = 0;

  muldiv_iter #(.WIDTH(32), .MUL_BITS(1)) u_mb1 (
    .clk(clk), .resetn(resetn), .start_i(start1), .op_i(op),
    .opdata1_i(d1), .opdata2_i(d2), .annul_i(annul),
    .busy_o(busy1), .ready_o(ready1), .result_o(res1), .div_by_zero_o(dbz1));

  muldiv_iter #(.WIDTH(32), .MUL_BITS(4)) u_mb4 (
    .clk(clk), .resetn(resetn), .start_i(start4), .op_i(op),
    .opdata1_i(d1), .opdata2_i(d2), .annul_i(annul),
    .busy_o(busy4), .ready_o(ready4), .result_o(res4), .div_by_zero_o(dbz4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // reference: {div_by_zero, hi, lo} from plain arithmetic
  function automatic logic [64:0] model(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    logic z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    case (f_op)
      2'd0: r = {32'd0, a} * {32'd0, b};
      2'd1: r = 64'(sa * sb);
      2'd2: if (b == 0) begin r = {a, 32'hFFFFFFFF}; z = 1'b1; end
            else r = {a % b, a / b};
      default: if (b == 0) begin r = {a, 32'hFFFFFFFF}; z = 1'b1; end
               else r = {32'(sa % sb), 32'(sa / sb)};
    endcase
    return {z, r};
  endfunction

  function automatic int exp_lat(input bit sel4, input logic [1:0] f_op, input logic [31:0] b);
    if (f_op[1] && b == 0) return 1;
    if (f_op[1]) return 34;
    return (sel4 ? 8 : 32) + 2;
  endfunction

  // runs one op; returns in the cycle after ready (or after a timeout)
  task automatic do_op(input bit sel4, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit noisy, output logic [63:0] r, output logic z, output int lat, output bit hs_ok);
    logic rdy, bsy;
    op = o; d1 = a; d2 = b;
    if (sel4) start4 = 1'b1; else start1 = 1'b1;
    cyc();
    start1 = 1'b0; start4 = 1'b0;
    lat = 1; hs_ok = 1'b1;
    forever begin
      rdy = sel4 ? ready4 : ready1;
      bsy = sel4 ? busy4 : busy1;
      if (!bsy) hs_ok = 1'b0;
      if (rdy || lat >= 200) break;
      if (noisy) begin
        op = 2'($urandom); d1 = $urandom; d2 = $urandom;
        if (sel4) start4 = 1'($urandom); else start1 = 1'($urandom);
      end
      cyc();
      lat++;
    end
    r = sel4 ? res4 : res1;
    z = sel4 ? dbz4 : dbz1;
    start1 = 1'b0; start4 = 1'b0;
    cyc();
    if ((sel4 ? busy4 : busy1) || (sel4 ? ready4 : ready1)) hs_ok = 1'b0;
    if ((sel4 ? res4 : res1) !== r) hs_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(); cyc();
    checks++; if (busy1 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset busy got %b/%b exp 0", busy1, busy4); end
    checks++; if (ready1 !== 1'b0 || ready4 !== 1'b0) begin errors++; $display("FAIL reset ready got %b/%b exp 0", ready1, ready4); end
    checks++; if (res1 !== 64'd0 || res4 !== 64'd0) begin errors++; $display("FAIL reset result got %h/%h exp 0", res1, res4); end
    checks++; if (dbz1 !== 1'b0 || dbz4 !== 1'b0) begin errors++; $display("FAIL reset dbz got %b/%b exp 0", dbz1, dbz4); end
    resetn = 1'b1;
    cyc();
  endtask

  typedef struct packed {
    bit          sel4;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    logic        z;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [7];
    logic [63:0] r; logic z; int lat; bit hs;
    tbl[0] = '{1'b0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 34};
    tbl[1] = '{1'b0, 2'd1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b0, 34};
    tbl[2] = '{1'b1, 2'd1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b0, 10};
    tbl[3] = '{1'b0, 2'd3, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
    tbl[4] = '{1'b0, 2'd2, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 34};
    tbl[5] = '{1'b0, 2'd2, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1, 1};
    tbl[6] = '{1'b0, 2'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].sel4, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, r, z, lat, hs);
      checks++; if (r !== tbl[i].r) begin errors++; $display("FAIL dir[%0d] result got %h exp %h", i, r, tbl[i].r); end
      checks++; if (z !== tbl[i].z) begin errors++; $display("FAIL dir[%0d] dbz got %b exp %b", i, z, tbl[i].z); end
      checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL dir[%0d] latency got %0d exp %0d", i, lat, tbl[i].lat); end
      checks++; if (hs !== 1'b1) begin errors++; $display("FAIL dir[%0d] busy/ready handshake got %b exp 1", i, hs); end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] r; logic z; int lat; bit hs; logic [64:0] m;
    logic [1:0] o; logic [31:0] a, b; bit s4;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom); a = pick(); b = pick(); s4 = 1'($urandom);
      m = model(o, a, b);
      do_op(s4, o, a, b, i[0], r, z, lat, hs);
      checks++; if (r !== m[63:0]) begin errors++; $display("FAIL rnd[%0d] op=%0d a=%h b=%h mb4=%0d result got %h exp %h", i, o, a, b, s4, r, m[63:0]); end
      checks++; if (z !== m[64]) begin errors++; $display("FAIL rnd[%0d] dbz got %b exp %b", i, z, m[64]); end
      checks++; if (lat !== exp_lat(s4, o, b)) begin errors++; $display("FAIL rnd[%0d] latency got %0d exp %0d", i, lat, exp_lat(s4, o, b)); end
      checks++; if (hs !== 1'b1) begin errors++; $display("FAIL rnd[%0d] handshake got %b exp 1", i, hs); end
    end
  endtask

  task automatic test_annul();
    logic [63:0] r, prev; logic z; int lat; bit hs; bit saw_rdy;
    // leave a div-by-zero result so both result and flag have non-default values
    do_op(1'b0, 2'd2, 32'd5, 32'd0, 1'b0, prev, z, lat, hs);
    op = 2'd1; d1 = 32'd1234; d2 = 32'hFFFFFF00; start1 = 1'b1;
    cyc();
    start1 = 1'b0; saw_rdy = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (ready1) saw_rdy = 1'b1;
      cyc();
    end
    annul = 1'b1;
    cyc();
    annul = 1'b0;
    if (ready1) saw_rdy = 1'b1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL annul_calc busy got %b exp 0", busy1); end
    checks++; if (saw_rdy !== 1'b0) begin errors++; $display("FAIL annul_calc ready seen got %b exp 0", saw_rdy); end
    checks++; if (res1 !== prev) begin errors++; $display("FAIL annul_calc result got %h exp %h", res1, prev); end
    checks++; if (dbz1 !== 1'b1) begin errors++; $display("FAIL annul_calc dbz got %b exp 1", dbz1); end
    do_op(1'b0, 2'd1, 32'hFFFFFFFE, 32'd9, 1'b0, r, z, lat, hs);
    checks++; if (r !== 64'hFFFFFFFF_FFFFFFEE) begin errors++; $display("FAIL annul_restart result got %h exp %h", r, 64'hFFFFFFFF_FFFFFFEE); end
    checks++; if (lat !== 34 || z !== 1'b0) begin errors++; $display("FAIL annul_restart latency/dbz got %0d/%b exp 34/0", lat, z); end
    // annul during FIX on the 4-bit instance (FIX is cycle T+9 there)
    prev = res4;
    op = 2'd0; d1 = 32'd3; d2 = 32'd3; start4 = 1'b1;
    cyc();
    start4 = 1'b0; saw_rdy = 1'b0;
    for (int k = 1; k < 9; k++) begin
      if (ready4) saw_rdy = 1'b1;
      cyc();
    end
    annul = 1'b1;
    cyc();
    annul = 1'b0;
    if (ready4) saw_rdy = 1'b1;
    cyc();
    if (ready4) saw_rdy = 1'b1;
    checks++; if (busy4 !== 1'b0 || saw_rdy !== 1'b0) begin errors++; $display("FAIL annul_fix busy/ready got %b/%b exp 0/0", busy4, saw_rdy); end
    checks++; if (res4 !== prev) begin errors++; $display("FAIL annul_fix result got %h exp %h", res4, prev); end
  endtask

  task automatic test_start_annul();
    logic [63:0] prev; bit saw;
    prev = res1;
    op = 2'd0; d1 = 32'd6; d2 = 32'd7; start1 = 1'b1; annul = 1'b1;
    cyc();
    start1 = 1'b0; annul = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL start_annul busy got %b exp 0", busy1); end
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ready1 || busy1) saw = 1'b1;
      cyc();
    end
    checks++; if (saw !== 1'b0 || res1 !== prev) begin errors++; $display("FAIL start_annul activity/result got %b/%h exp 0/%h", saw, res1, prev); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r; logic z; int lat; bit hs;
    do_op(1'b0, 2'd2, 32'd1000, 32'd33, 1'b0, r, z, lat, hs);
    checks++; if (r !== {32'd10, 32'd30} || lat !== 34) begin errors++; $display("FAIL b2b_first result/lat got %h/%0d exp %h/34", r, lat, {32'd10, 32'd30}); end
    do_op(1'b0, 2'd3, 32'd1000, 32'hFFFFFFDF, 1'b0, r, z, lat, hs);
    checks++; if (r !== {32'd10, 32'hFFFFFFE2} || lat !== 34) begin errors++; $display("FAIL b2b_second result/lat got %h/%0d exp %h/34", r, lat, {32'd10, 32'hFFFFFFE2}); end
    do_op(1'b0, 2'd3, 32'd8, 32'd0, 1'b0, r, z, lat, hs);
    checks++; if (r !== {32'd8, 32'hFFFFFFFF} || z !== 1'b1 || lat !== 1) begin errors++; $display("FAIL b2b_dbz result/dbz/lat got %h/%b/%0d exp %h/1/1", r, z, lat, {32'd8, 32'hFFFFFFFF}); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; logic z; int lat; bit hs;
    do_op(1'b0, 2'd0, 32'd12345, 32'd678, 1'b0, r, z, lat, hs);
    op = 2'd3; d1 = 32'd77; d2 = 32'd0; start1 = 1'b1;
    cyc();
    op = 2'd2; d1 = 32'd77; d2 = 32'd5;
    cyc();
    start1 = 1'b0;
    for (int k = 2; k < 5; k++) cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    checks++; if (busy1 !== 1'b0 || ready1 !== 1'b0) begin errors++; $display("FAIL reset_mid busy/ready got %b/%b exp 0/0", busy1, ready1); end
    checks++; if (res1 !== 64'd0 || dbz1 !== 1'b0) begin errors++; $display("FAIL reset_mid result/dbz got %h/%b exp 0/0", res1, dbz1); end
    cyc();
    do_op(1'b0, 2'd2, 32'd77, 32'd5, 1'b0, r, z, lat, hs);
    checks++; if (r !== {32'd2, 32'd15} || lat !== 34) begin errors++; $display("FAIL reset_recover result/lat got %h/%0d exp %h/34", r, lat, {32'd2, 32'd15}); end
  endtask

  initial begin
    resetn = 1'b0; start1 = 1'b0; start4 = 1'b0; annul = 1'b0;
    op = 2'd0; d1 = '0; d2 = '0;
    test_reset();
    test_directed();
    test_annul();
    test_start_annul();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It replaces the separate fixed-32-bit mul and div blocks with one shared engine.
- Supports signed and unsigned multiply and divide, with a configurable bit-width and multiply bits-per-cycle.
- Uses a start/ready handshake with annul, and reports divide-by-zero.
- Result is packed as {hi, lo} and feeds the HI/LO write path directly.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH.
- MUL_BITS, 1, multiplier bits retired per cycle; legal values are 1, 2, 4; WIDTH must be divisible by MUL_BITS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset; synchronous, active-low.
- start_i  input  1  request a new operation; sampled only in IDLE.
- op_i  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- opdata1_i  input  WIDTH  multiplicand or dividend.
- opdata2_i  input  WIDTH  multiplier or divisor.
- annul_i  input  1  abort the current or requested operation.
- busy_o  output  1  high whenever the state is not IDLE.
- ready_o  output  1  one-cycle pulse when result_o becomes valid.
- result_o  output  2*WIDTH  {hi, lo}: product[2W-1:0], or {remainder, quotient}.
- div_by_zero_o  output  1  valid with ready_o; high when the divisor was zero; holds until the next accept.

Behaviour:
- Reset: when resetn=0 at a clock edge, every output goes to 0 and state goes to IDLE. This applies mid-operation too; the in-flight operation is discarded.
- States: IDLE, CALC, FIX, DONE.

IDLE:
- Accept happens at cycle T when start_i=1 and annul_i=0.
- On accept, latch op_i, the operand magnitudes, the sign flags and the zero-divisor flag.
- Magnitudes are two's-complement absolute values, and are taken only for signed ops.
- start_i together with annul_i is not accepted.

Transitions:
- IDLE -> CALC on accept.
- Exception: a divide with opdata2_i==0 goes IDLE -> DONE, so ready_o is asserted at T+1.

CALC:
- Counter runs N = WIDTH/MUL_BITS cycles for multiply, N = WIDTH for divide.
- Multiply: shift-add; each cycle adds (multiplicand * next MUL_BITS of multiplier) into the 2W accumulator.
- Divide: radix-2 restoring; each cycle shifts the partial remainder left, subtracts the divisor, and sets the quotient bit when the result is non-negative.
- The counter is WIDTH-sized and has no wrap; after the last step go to FIX.

FIX (one cycle):
- mult: negate the 2W product when the operand signs differ.
- div: negate the quotient when the signs differ; give the remainder the sign of the dividend.
- Then go to DONE.

DONE (one cycle):
- ready_o=1 and result_o is registered valid; next state is IDLE.
- result_o and div_by_zero_o then hold stable until the next accept.

Latency:
- start to ready_o is N+2 cycles: 34 for 32-bit div, or for mul with MUL_BITS=1.
- div-by-zero takes 1 cycle.
- Back-to-back: the next accept can occur in the cycle after ready_o.

Divide by zero:
- lo = all ones, hi = dividend (raw opdata1_i), div_by_zero_o=1.

Signed overflow (-2^(W-1) / -1):
- lo = 0x80..0 (wraps), hi = 0; no flag.

Busy and annul:
- start_i while busy is ignored; operand changes during busy are ignored.
- annul_i in CALC or FIX: next state is IDLE, no ready_o pulse, result_o and div_by_zero_o unchanged.
- annul_i in DONE does not suppress that cycle's ready_o.

Width rules:
- All arithmetic is modulo 2^(2W) for products, or W bits for quotient and remainder.
- No X propagation: unused accumulator bits are cleared on accept.

Test Plan (WIDTH=32, MUL_BITS=1 unless noted):
- multu 0xFFFFFFFF*0xFFFFFFFF at T -> busy_o high T+1..T+34; ready_o exactly at T+34; result_o=0xFFFFFFFE_00000001.
- mult -3*7 -> result_o=0xFFFFFFFF_FFFFFFEB. Repeat with MUL_BITS=4 -> same result, ready_o at T+10.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2. Both have ready_o at T+34.
- divu 5/0 -> ready_o at T+1, div_by_zero_o=1, hi=5, lo=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero_o=0.
- Abort and reset cases:
  - Start mult, pulse annul_i at T+10 -> no ready_o, busy_o low at T+11, result_o keeps its previous value; a new start at T+11 completes normally.
  - start_i with annul_i in the same cycle -> not accepted.
  - resetn low at T+5 -> all outputs 0 next cycle.
